// File: rtl/pipe_ctrl_pkg.sv
`timescale 1ns/1ps
// pipe_ctrl_pkg
// Shared definitions for the pipeline main controller:
//   - opcode constants for the 4-bit base opcode space
//   - ALU operation codes driven into EX
//   - ctrl_t : the ID/EX control bundle
//   - CTRL_BUBBLE : the all-zero bundle used for bubbles
//   - state_e : controller FSM states
package pipe_ctrl_pkg;

    localparam logic [3:0] OP_RTYPE = 4'h0;
    localparam logic [3:0] OP_IN    = 4'h1;
    localparam logic [3:0] OP_OUT   = 4'h2;
    localparam logic [3:0] OP_JR    = 4'h3;
    localparam logic [3:0] OP_ADDI  = 4'h4;
    localparam logic [3:0] OP_ANDI  = 4'h5;
    localparam logic [3:0] OP_ORI   = 4'h6;
    localparam logic [3:0] OP_LW    = 4'h7;
    localparam logic [3:0] OP_SW    = 4'h8;
    localparam logic [3:0] OP_BEQ   = 4'h9;
    localparam logic [3:0] OP_BNE   = 4'hA;
    localparam logic [3:0] OP_J     = 4'hB;
    localparam logic [3:0] OP_JAL   = 4'hC;
    localparam logic [3:0] OP_RSVD  = 4'hD;
    localparam logic [3:0] OP_NOP   = 4'hE;
    localparam logic [3:0] OP_HALT  = 4'hF;

    localparam logic [2:0] ALU_ADD   = 3'd0;
    localparam logic [2:0] ALU_PASS  = 3'd1;
    localparam logic [2:0] ALU_SUB   = 3'd2;
    localparam logic [2:0] ALU_AND   = 3'd5;
    localparam logic [2:0] ALU_OR    = 3'd6;
    localparam logic [2:0] ALU_FUNCT = 3'd7;

    typedef struct packed {
        logic [2:0] alu_op;
        logic [1:0] regdst;
        logic [1:0] memtoreg;
        logic       alusrc;
        logic       memread;
        logic       memwrite;
        logic       regwrite;
        logic       branch;
        logic       branch_ne;
        logic       jump;
        logic       jump_r;
        logic       in_en;
        logic       out_en;
        logic       sext_mode;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

    typedef enum logic [2:0] {
        ST_RUN      = 3'd0,
        ST_WAIT_IN  = 3'd1,
        ST_WAIT_OUT = 3'd2,
        ST_DRAIN    = 3'd3,
        ST_HALTED   = 3'd4
    } state_e;

endpackage

// File: rtl/op_decode.sv
`timescale 1ns/1ps
// op_decode
// Purely combinational opcode decoder for the ID stage.
// Ports:
//   opcode  [OPCODE_W-1:0] in  : opcode of the instruction in ID
//   ctrl    ctrl_t         out : decoded control bundle (all zero for NOP,
//                                HALT and illegal opcodes)
//   illegal                out : opcode is reserved (D) or has high bits set
//   is_halt                out : opcode is HALT
module op_decode
    import pipe_ctrl_pkg::*;
#(
    parameter int OPCODE_W = 4
) (
    input  logic [OPCODE_W-1:0] opcode,
    output ctrl_t               ctrl,
    output logic                illegal,
    output logic                is_halt
);

    // Any set bit above the 4-bit base opcode space makes the opcode illegal.
    logic high_set;

    generate
        if (OPCODE_W > 4) begin : g_wide
            assign high_set = |opcode[OPCODE_W-1:4];
        end else begin : g_narrow
            assign high_set = 1'b0;
        end
    endgenerate

    always_comb begin
        ctrl    = CTRL_BUBBLE;
        illegal = 1'b0;
        is_halt = 1'b0;
        if (high_set) begin
            illegal = 1'b1;
        end else begin
            case (opcode[3:0])
                OP_RTYPE: begin
                    ctrl.alu_op   = ALU_FUNCT;
                    ctrl.regdst   = 2'd1;
                    ctrl.regwrite = 1'b1;
                end
                OP_IN: begin
                    ctrl.regdst   = 2'd1;
                    ctrl.regwrite = 1'b1;
                    ctrl.in_en    = 1'b1;
                end
                OP_OUT: begin
                    ctrl.alu_op = ALU_PASS;
                    ctrl.out_en = 1'b1;
                end
                OP_JR: begin
                    ctrl.jump_r = 1'b1;
                end
                OP_ADDI: begin
                    ctrl.alu_op    = ALU_ADD;
                    ctrl.alusrc    = 1'b1;
                    ctrl.regwrite  = 1'b1;
                    ctrl.sext_mode = 1'b0;
                end
                OP_ANDI: begin
                    ctrl.alu_op    = ALU_AND;
                    ctrl.alusrc    = 1'b1;
                    ctrl.regwrite  = 1'b1;
                    ctrl.sext_mode = 1'b1;
                end
                OP_ORI: begin
                    ctrl.alu_op    = ALU_OR;
                    ctrl.alusrc    = 1'b1;
                    ctrl.regwrite  = 1'b1;
                    ctrl.sext_mode = 1'b1;
                end
                OP_LW: begin
                    ctrl.alu_op   = ALU_ADD;
                    ctrl.alusrc   = 1'b1;
                    ctrl.memtoreg = 2'd1;
                    ctrl.memread  = 1'b1;
                    ctrl.regwrite = 1'b1;
                end
                OP_SW: begin
                    ctrl.alu_op   = ALU_ADD;
                    ctrl.alusrc   = 1'b1;
                    ctrl.memwrite = 1'b1;
                end
                OP_BEQ: begin
                    ctrl.alu_op = ALU_SUB;
                    ctrl.branch = 1'b1;
                end
                OP_BNE: begin
                    ctrl.alu_op    = ALU_SUB;
                    ctrl.branch_ne = 1'b1;
                end
                OP_J: begin
                    ctrl.jump = 1'b1;
                end
                OP_JAL: begin
                    ctrl.regdst   = 2'd2;
                    ctrl.memtoreg = 2'd2;
                    ctrl.regwrite = 1'b1;
                    ctrl.jump     = 1'b1;
                end
                OP_NOP: begin
                end
                OP_HALT: begin
                    is_halt = 1'b1;
                end
                default: begin
                    // Only OP_RSVD reaches here.
                    illegal = 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/pipe_main_ctrl.sv
`timescale 1ns/1ps
// pipe_main_ctrl
// Main pipeline controller: decodes the ID opcode, registers the ID/EX
// control bundle, inserts bubbles for stall/flush, waits on external I/O
// handshakes for IN/OUT, and drains the pipeline before halting.
// Ports:
//   clk, rst (sync, active-high)
//   opcode, id_valid       : instruction in ID
//   stall, flush           : hazard unit controls (flush wins)
//   in_valid, out_ready    : external I/O handshake
//   ex_*                   : registered ID/EX control bundle
//   ex_valid, ex_illegal   : bundle is real / illegal-opcode pulse
//   pc_hold (comb)         : freeze PC and IF/ID
//   halted                 : sticky halt status
module pipe_main_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int OPCODE_W     = 4,
    parameter int ALUOP_W      = 3,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                id_valid,
    input  logic                stall,
    input  logic                flush,
    input  logic                in_valid,
    input  logic                out_ready,
    output logic [ALUOP_W-1:0]  ex_alu_op,
    output logic [1:0]          ex_regdst,
    output logic [1:0]          ex_memtoreg,
    output logic                ex_alusrc,
    output logic                ex_memread,
    output logic                ex_memwrite,
    output logic                ex_regwrite,
    output logic                ex_branch,
    output logic                ex_branch_ne,
    output logic                ex_jump,
    output logic                ex_jump_r,
    output logic                ex_in,
    output logic                ex_out,
    output logic                ex_sext_mode,
    output logic                ex_valid,
    output logic                ex_illegal,
    output logic                pc_hold,
    output logic                halted
);

    localparam int CNT_W = $clog2(DRAIN_CYCLES + 1);

    localparam logic [2:0] S_RUN      = ST_RUN;
    localparam logic [2:0] S_WAIT_IN  = ST_WAIT_IN;
    localparam logic [2:0] S_WAIT_OUT = ST_WAIT_OUT;
    localparam logic [2:0] S_DRAIN    = ST_DRAIN;
    localparam logic [2:0] S_HALTED   = ST_HALTED;

    ctrl_t             dec;
    logic              dec_illegal;
    logic              dec_halt;

    logic [2:0]        state, state_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    ctrl_t             ex_q, ex_n;
    logic              valid_q, valid_n;
    logic              illegal_q, illegal_n;
    logic              hold_c;

    op_decode #(
        .OPCODE_W (OPCODE_W)
    ) u_decode (
        .opcode  (opcode),
        .ctrl    (dec),
        .illegal (dec_illegal),
        .is_halt (dec_halt)
    );

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        ex_n      = CTRL_BUBBLE;
        valid_n   = 1'b0;
        illegal_n = 1'b0;
        hold_c    = 1'b0;
        case (state)
            S_RUN: begin
                hold_c = stall & ~flush;
                if (id_valid && !stall && !flush) begin
                    if (dec_halt) begin
                        // HALT itself never reaches EX; it only starts the drain.
                        state_n = S_DRAIN;
                        cnt_n   = CNT_W'(DRAIN_CYCLES);
                    end else if (dec.in_en && !in_valid) begin
                        state_n = S_WAIT_IN;
                        hold_c  = 1'b1;
                    end else if (dec.out_en && !out_ready) begin
                        state_n = S_WAIT_OUT;
                        hold_c  = 1'b1;
                    end else begin
                        ex_n      = dec;
                        valid_n   = 1'b1;
                        illegal_n = dec_illegal;
                    end
                end
            end
            S_WAIT_IN, S_WAIT_OUT: begin
                hold_c = 1'b1;
                if (flush) begin
                    state_n = S_RUN;
                end else if ((state == S_WAIT_IN) ? (in_valid && !stall)
                                                  : (out_ready && !stall)) begin
                    // Release the freeze on the issuing edge so the held IN/OUT
                    // leaves IF/ID instead of being issued a second time.
                    ex_n    = dec;
                    valid_n = 1'b1;
                    hold_c  = 1'b0;
                    state_n = S_RUN;
                end
            end
            S_DRAIN: begin
                hold_c = 1'b1;
                if (cnt != '0) begin
                    cnt_n = cnt - CNT_W'(1);
                end
                if (cnt <= CNT_W'(1)) begin
                    state_n = S_HALTED;
                end
            end
            S_HALTED: begin
                hold_c = 1'b1;
            end
            default: begin
                state_n = S_RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_RUN;
            cnt       <= '0;
            ex_q      <= CTRL_BUBBLE;
            valid_q   <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            ex_q      <= ex_n;
            valid_q   <= valid_n;
            illegal_q <= illegal_n;
        end
    end

    assign pc_hold      = hold_c & ~rst;
    assign halted       = (state == S_HALTED);
    assign ex_valid     = valid_q;
    assign ex_illegal   = illegal_q;
    assign ex_alu_op    = ALUOP_W'(ex_q.alu_op);
    assign ex_regdst    = ex_q.regdst;
    assign ex_memtoreg  = ex_q.memtoreg;
    assign ex_alusrc    = ex_q.alusrc;
    assign ex_memread   = ex_q.memread;
    assign ex_memwrite  = ex_q.memwrite;
    assign ex_regwrite  = ex_q.regwrite;
    assign ex_branch    = ex_q.branch;
    assign ex_branch_ne = ex_q.branch_ne;
    assign ex_jump      = ex_q.jump;
    assign ex_jump_r    = ex_q.jump_r;
    assign ex_in        = ex_q.in_en;
    assign ex_out       = ex_q.out_en;
    assign ex_sext_mode = ex_q.sext_mode;

endmodule

// File: tb/tb_pipe_main_ctrl.sv
`timescale 1ns/1ps
// tb_pipe_main_ctrl
// Directed bench for pipe_main_ctrl with a 6-bit opcode. The stimulus process
// pushes the expected bundle of every instruction it expects to issue; the
// monitor pops one entry whenever ex_valid is seen and otherwise requires a
// clean bubble.
module tb_pipe_main_ctrl;

    localparam int OW = 6;
    localparam int AW = 3;
    localparam int DC = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [OW-1:0] opcode;
    logic          id_valid, stall, flush, in_valid, out_ready;
    logic [AW-1:0] ex_alu_op;
    logic [1:0]    ex_regdst, ex_memtoreg;
    logic          ex_alusrc, ex_memread, ex_memwrite, ex_regwrite;
    logic          ex_branch, ex_branch_ne, ex_jump, ex_jump_r;
    logic          ex_in, ex_out, ex_sext_mode;
    logic          ex_valid, ex_illegal, pc_hold, halted;

    always #5 clk = ~clk;

    pipe_main_ctrl #(
        .OPCODE_W     (OW),
        .ALUOP_W      (AW),
        .DRAIN_CYCLES (DC)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .opcode       (opcode),
        .id_valid     (id_valid),
        .stall        (stall),
        .flush        (flush),
        .in_valid     (in_valid),
        .out_ready    (out_ready),
        .ex_alu_op    (ex_alu_op),
        .ex_regdst    (ex_regdst),
        .ex_memtoreg  (ex_memtoreg),
        .ex_alusrc    (ex_alusrc),
        .ex_memread   (ex_memread),
        .ex_memwrite  (ex_memwrite),
        .ex_regwrite  (ex_regwrite),
        .ex_branch    (ex_branch),
        .ex_branch_ne (ex_branch_ne),
        .ex_jump      (ex_jump),
        .ex_jump_r    (ex_jump_r),
        .ex_in        (ex_in),
        .ex_out       (ex_out),
        .ex_sext_mode (ex_sext_mode),
        .ex_valid     (ex_valid),
        .ex_illegal   (ex_illegal),
        .pc_hold      (pc_hold),
        .halted       (halted)
    );

    typedef struct packed {
        logic [2:0] alu;
        logic [1:0] regdst;
        logic [1:0] memtoreg;
        logic       alusrc;
        logic       memread;
        logic       memwrite;
        logic       regwrite;
        logic       branch;
        logic       branch_ne;
        logic       jump;
        logic       jump_r;
        logic       inp;
        logic       outp;
        logic       sext;
        logic       illegal;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Hand-written decode table for the opcodes the bench issues.
    function automatic exp_t expected_for(input logic [OW-1:0] op);
        exp_t e;
        e = '0;
        case (op)
            6'h00: begin e.alu = 3'd7; e.regdst = 2'd1; e.regwrite = 1'b1; end
            6'h01: begin e.regdst = 2'd1; e.regwrite = 1'b1; e.inp = 1'b1; end
            6'h02: begin e.alu = 3'd1; e.outp = 1'b1; end
            6'h04: begin e.alusrc = 1'b1; e.regwrite = 1'b1; end
            6'h05: begin e.alu = 3'd5; e.alusrc = 1'b1; e.regwrite = 1'b1; e.sext = 1'b1; end
            6'h07: begin e.alusrc = 1'b1; e.memtoreg = 2'd1; e.memread = 1'b1; e.regwrite = 1'b1; end
            6'h08: begin e.alusrc = 1'b1; e.memwrite = 1'b1; end
            6'h09: begin e.alu = 3'd2; e.branch = 1'b1; end
            6'h0E: begin end
            default: begin e.illegal = 1'b1; end
        endcase
        return e;
    endfunction

    function automatic exp_t actual_bundle();
        exp_t a;
        a.alu       = ex_alu_op;
        a.regdst    = ex_regdst;
        a.memtoreg  = ex_memtoreg;
        a.alusrc    = ex_alusrc;
        a.memread   = ex_memread;
        a.memwrite  = ex_memwrite;
        a.regwrite  = ex_regwrite;
        a.branch    = ex_branch;
        a.branch_ne = ex_branch_ne;
        a.jump      = ex_jump;
        a.jump_r    = ex_jump_r;
        a.inp       = ex_in;
        a.outp      = ex_out;
        a.sext      = ex_sext_mode;
        a.illegal   = ex_illegal;
        return a;
    endfunction

    task automatic checkOutput(input string name, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got %b expected %b at %0t", name, act, req, $time);
        end
    endtask

    task automatic applyStimulus(input logic [OW-1:0] op, input logic idv, input logic stl,
                                 input logic fl, input logic inv, input logic outr);
        opcode    = op;
        id_valid  = idv;
        stall     = stl;
        flush     = fl;
        in_valid  = inv;
        out_ready = outr;
    endtask

    task automatic expectIssue(input logic [OW-1:0] op);
        exp_q.push_back(expected_for(op));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: outputs are registered, so sampling on the falling edge is stable.
    always @(negedge clk) begin
        exp_t a;
        exp_t e;
        a = actual_bundle();
        if (ex_valid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_issue: got bundle %h with nothing expected at %0t", a, $time);
            end else begin
                e = exp_q.pop_front();
                if (a !== e) begin
                    errors++;
                    $display("[TB] FAIL issue_bundle: got %h expected %h at %0t", a, e, $time);
                end
            end
        end else begin
            checks++;
            if (a !== '0 || ex_valid !== 1'b0) begin
                errors++;
                $display("[TB] FAIL bubble: got %h valid %b expected all zero at %0t", a, ex_valid, $time);
            end
        end
    end

    initial begin
        #50000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [OW-1:0] seq_a [5];
        seq_a = '{6'h04, 6'h07, 6'h08, 6'h09, 6'h00};

        // Reset, with inputs that would otherwise stall and issue.
        rst = 1'b1;
        applyStimulus(6'h04, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        #1 checkOutput("pc_hold_in_reset", pc_hold, 1'b0);
        tick();
        tick();
        checkOutput("halted_after_reset", halted, 1'b0);
        checkOutput("valid_after_reset", ex_valid, 1'b0);
        rst = 1'b0;

        // Back-to-back issue of ADDI, LW, SW, BEQ, R-type.
        foreach (seq_a[i]) begin
            applyStimulus(seq_a[i], 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
            expectIssue(seq_a[i]);
            #1 checkOutput("pc_hold_run", pc_hold, 1'b0);
            tick();
        end

        // LW stalled twice, then issued; then stall and flush together.
        for (int i = 0; i < 2; i++) begin
            applyStimulus(6'h07, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
            #1 checkOutput("pc_hold_stall", pc_hold, 1'b1);
            tick();
        end
        applyStimulus(6'h07, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        expectIssue(6'h07);
        tick();
        applyStimulus(6'h07, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        #1 checkOutput("pc_hold_stall_flush", pc_hold, 1'b0);
        tick();

        // IN waiting three cycles on in_valid, then issued.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(6'h01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
            #1 checkOutput("pc_hold_wait_in", pc_hold, 1'b1);
            tick();
        end
        applyStimulus(6'h01, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        expectIssue(6'h01);
        tick();

        // IN wait abandoned by flush; an ADDI right after must issue from RUN.
        applyStimulus(6'h01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        #1 checkOutput("pc_hold_wait_in2", pc_hold, 1'b1);
        tick();
        applyStimulus(6'h01, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        tick();
        applyStimulus(6'h04, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        expectIssue(6'h04);
        #1 checkOutput("pc_hold_after_flush_wait", pc_hold, 1'b0);
        tick();

        // OUT waiting one cycle on out_ready.
        applyStimulus(6'h02, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        #1 checkOutput("pc_hold_wait_out", pc_hold, 1'b1);
        tick();
        applyStimulus(6'h02, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        expectIssue(6'h02);
        tick();

        // Illegal opcodes (high bit set, reserved D), then a legal NOP, then idle.
        applyStimulus(6'h14, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        expectIssue(6'h14);
        tick();
        applyStimulus(6'h0D, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        expectIssue(6'h0D);
        tick();
        applyStimulus(6'h0E, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        expectIssue(6'h0E);
        tick();
        applyStimulus(6'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();

        // HALT: halted rises exactly three edges after the issuing edge,
        // while ADDI with flush in DRAIN must not issue.
        applyStimulus(6'h0F, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        for (int k = 0; k < 4; k++) begin
            checkOutput("halted_timing", halted, k == 3);
            checkOutput("pc_hold_drain_halted", pc_hold, 1'b1);
            applyStimulus(6'h04, 1'b1, 1'b0, k < 2, 1'b0, 1'b1);
            tick();
        end
        checkOutput("halted_sticky", halted, 1'b1);

        // Reset out of HALTED, then a normal issue.
        rst = 1'b1;
        applyStimulus(6'h05, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        #1 checkOutput("pc_hold_reset_halted", pc_hold, 1'b0);
        tick();
        checkOutput("halted_cleared", halted, 1'b0);
        rst = 1'b0;
        expectIssue(6'h05);
        #1 checkOutput("pc_hold_after_reset", pc_hold, 1'b0);
        tick();
        applyStimulus(6'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        tick();

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL leftover_expected: got %0d pending expected 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipe_main_ctrl.md
PIPE_MAIN_CTRL -- requirements
Module: pipe_main_ctrl

Interface
REQ-001 The block SHALL have parameter OPCODE_W, default 4, giving the opcode width in bits (at least 4).
REQ-002 The block SHALL have parameter ALUOP_W, default 3, giving the ALU operation code width.
REQ-003 The block SHALL have parameter DRAIN_CYCLES, default 3, giving the cycles between HALT issue and `halted` (at least 1).
REQ-004 The block SHALL have port `clk`, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port `rst`, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port `opcode`, input, OPCODE_W bits: opcode of the instruction in ID.
REQ-007 The block SHALL have port `id_valid`, input, 1 bit: ID holds a real instruction.
REQ-008 The block SHALL have port `stall`, input, 1 bit: hazard unit requests hold.
REQ-009 The block SHALL have port `flush`, input, 1 bit: kill the ID instruction.
REQ-010 The block SHALL have port `in_valid`, input, 1 bit: external input data available.
REQ-011 The block SHALL have port `out_ready`, input, 1 bit: external output sink ready.
REQ-012 The block SHALL have ports `ex_alu_op` (ALUOP_W bits), `ex_regdst` (2), `ex_memtoreg` (2), `ex_alusrc`, `ex_memread`, `ex_memwrite`, `ex_regwrite`, `ex_branch`, `ex_branch_ne`, `ex_jump`, `ex_jump_r`, `ex_in`, `ex_out`, `ex_sext_mode` (1 bit each), all outputs: the registered ID/EX control bundle.
REQ-013 The block SHALL have port `ex_valid`, output, 1 bit: the EX bundle is a real instruction.
REQ-014 The block SHALL have port `ex_illegal`, output, 1 bit: a registered one-cycle pulse flagging an illegal opcode.
REQ-015 The block SHALL have port `pc_hold`, output, 1 bit, combinational: freeze PC and IF/ID.
REQ-016 The block SHALL have port `halted`, output, 1 bit: sticky halt status.

Function
REQ-017 The decode table SHALL be as follows; every field not listed is 0, including all don't-care fields:
- 0: R-type — alu 7, regdst 1, regwrite.
- 1: IN — regdst 1, regwrite, in.
- 2: OUT — alu 1, out.
- 3: JR — jump_r.
- 4: ADDI — alu 0, alusrc, regwrite, sext 0.
- 5: ANDI — alu 5, alusrc, regwrite, sext 1.
- 6: ORI — alu 6, alusrc, regwrite, sext 1.
- 7: LW — alu 0, alusrc, memtoreg 1, memread, regwrite.
- 8: SW — alu 0, alusrc, memwrite.
- 9: BEQ — alu 2, branch.
- A: BNE — alu 2, branch_ne.
- B: J — jump.
- C: JAL — regdst 2, memtoreg 2, regwrite, jump.
- E: NOP.
- F: HALT.
REQ-018 Opcode D, or any opcode with a nonzero bit above bit 3, SHALL decode as NOP and SHALL set `ex_illegal` for one cycle when issued.
REQ-019 A bubble SHALL be an all-zero bundle with `ex_valid`=0 and `ex_illegal`=0.
REQ-020 Issue SHALL occur when `id_valid`=1, `stall`=0, `flush`=0 and the state permits; the decoded bundle then appears on the ex_* outputs one cycle later with `ex_valid`=1.
REQ-021 When issue does not occur, a bubble SHALL be registered.
REQ-022 `flush` SHALL take priority over `stall`; both produce a bubble; `pc_hold`=`stall`&!`flush` in RUN.
REQ-023 The FSM SHALL have states RUN, WAIT_IN, WAIT_OUT, DRAIN and HALTED.
REQ-024 In RUN with IN in ID and `in_valid`=0, the block SHALL register a bubble, assert `pc_hold` and enter WAIT_IN; OUT with `out_ready`=0 SHALL behave the same way, entering WAIT_OUT.
REQ-025 In WAIT_IN and WAIT_OUT, `pc_hold`=1.
REQ-026 In WAIT_IN, the block SHALL issue IN and return to RUN in the cycle `in_valid`=1 and `stall`=0; WAIT_OUT SHALL do the same with `out_ready`.
REQ-027 A `flush` in WAIT_IN or WAIT_OUT SHALL abandon the wait, register a bubble and return to RUN.
REQ-028 An issued HALT SHALL register a bubble, load the drain counter with DRAIN_CYCLES and enter DRAIN.
REQ-029 In DRAIN, the block SHALL register bubbles, hold `pc_hold`=1, ignore `flush`/`stall`, and decrement the counter each cycle; at count 1 it SHALL enter HALTED.
REQ-030 HALTED SHALL assert `halted`=1 and `pc_hold`=1 and register bubbles until `rst`.
REQ-031 A stalled or flushed HALT SHALL have no effect.
REQ-032 The drain counter width SHALL be clog2(DRAIN_CYCLES+1), with no wrap.

Reset
REQ-033 With `rst`=1 at a clock edge, the block SHALL set state=RUN, counter=0, all ex_* outputs=0, `ex_valid`=0, `ex_illegal`=0 and `halted`=0.
REQ-034 Reset SHALL take priority over every input, including mid-WAIT, mid-DRAIN and HALTED.
REQ-035 `pc_hold` SHALL be 0 during reset.

Structure
REQ-036 Package pipe_ctrl_pkg SHALL hold the opcode constants, the control-bundle struct, the FSM state enum and the bubble constant.
REQ-037 The combinational table SHALL be sub-module op_decode (opcode in, bundle plus illegal out), instantiated once.

Verification
REQ-038 Sequence 4,7,8,9,0 with no stall SHALL give, one cycle later each: alu 0/0/0/2/7, memread only on 7, memwrite only on 8, branch only on 9, ex_valid=1 each.
REQ-039 LW with `stall`=1 for 2 cycles SHALL give 2 bubbles, `pc_hold`=1 for those 2 cycles, then the LW bundle; `stall`+`flush` together SHALL give a bubble with `pc_hold`=0.
REQ-040 IN with `in_valid` low for 3 cycles SHALL give WAIT_IN, 3 bubbles, then `ex_in`=1, `ex_regwrite`=1 the cycle after `in_valid` rises; a repeat with `flush` mid-wait SHALL return to RUN with no IN issued.
REQ-041 HALT issued with DRAIN_CYCLES=3 SHALL raise `halted` exactly 3 cycles after issue, with `flush` in DRAIN ignored; `rst` then SHALL clear `halted` within 1 cycle.
REQ-042 With OPCODE_W=6, opcode 0x14 and opcode 0xD SHALL give a NOP bundle with `ex_illegal`=1 for one cycle, `ex_valid`=1 and all enables 0.
